// File: rtl/fp_conv_sequencer.sv
// fp_conv_sequencer: round-robin shared 12-bit two's-complement to (S,E[2:0],F[3:0]) float converter
module fp_conv_sequencer #(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [11:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [11:0] b_data,
  output logic        b_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_s,
  output logic [2:0]  out_e,
  output logic [3:0]  out_f,
  output logic        out_id,
  output logic        busy
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ABS   = 3'd1;
  localparam logic [2:0] NORM  = 3'd2;
  localparam logic [2:0] ROUND = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;
  logic [2:0]  state;
  logic        last_grant, id, s;
  logic [11:0] data, m, sh;
  logic [3:0]  lz, lz_n, f_n, f_r;
  logic [2:0]  e_n, e_r;
  logic        r_n, inc;
  assign busy    = state != IDLE;
  assign a_ready = state == IDLE && a_valid && (!b_valid || last_grant);
  assign b_ready = state == IDLE && b_valid && (!a_valid || !last_grant);
  always_comb begin
    lz_n = 4'd12;
    for (int i = 0; i < 12; i++) if (m[i]) lz_n = 4'(11 - i);
  end
  // the leading one lands in f[3]; lz==0 only happens for the 0x800 magnitude
  assign sh  = m >> (4'd7 - lz);
  assign e_n = lz == 4'd0 ? 3'd7 : lz <= 4'd7 ? 3'(4'd8 - lz) : 3'd0;
  assign f_n = lz == 4'd0 ? 4'hf : lz <= 4'd7 ? sh[4:1] : m[3:0];
  assign r_n = lz != 4'd0 && lz <= 4'd7 && sh[0];
  assign inc = ROUND_EN && r_n;
  assign e_r = !inc || f_n != 4'hf ? e_n : e_n == 3'd7 ? 3'd7 : e_n + 3'd1;
  assign f_r = !inc ? f_n : f_n != 4'hf ? f_n + 4'd1 : e_n == 3'd7 ? 4'hf : 4'h8;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      data       <= '0;
      id         <= 1'b0;
      s          <= 1'b0;
      m          <= '0;
      lz         <= '0;
      out_valid  <= 1'b0;
      out_s      <= 1'b0;
      out_e      <= '0;
      out_f      <= '0;
      out_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (a_ready || b_ready) begin
          data       <= b_ready ? b_data : a_data;
          id         <= b_ready;
          last_grant <= b_ready;
          state      <= ABS;
        end
        ABS: begin
          s     <= data[11];
          m     <= data[11] ? -data : data;
          state <= NORM;
        end
        NORM: begin
          lz    <= lz_n;
          state <= ROUND;
        end
        ROUND: begin
          out_s     <= s;
          out_e     <= e_r;
          out_f     <= f_r;
          out_id    <= id;
          out_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_conv_sequencer.sv
// tb_fp_conv_sequencer: directed vectors against hand-computed float encodings
module tb_fp_conv_sequencer;
  logic        clk = 0, rst = 1;
  logic        a_valid = 0, b_valid = 0, out_ready = 0;
  logic [11:0] a_data = 0, b_data = 0;
  logic        a_ready, b_ready, out_valid, out_s, out_id, busy;
  logic [2:0]  out_e;
  logic [3:0]  out_f;
  logic        a_ready_t, b_ready_t, out_valid_t, out_s_t, out_id_t, busy_t;
  logic [2:0]  out_e_t;
  logic [3:0]  out_f_t;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  fp_conv_sequencer #(.ROUND_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_s(out_s), .out_e(out_e), .out_f(out_f), .out_id(out_id), .busy(busy));
  fp_conv_sequencer #(.ROUND_EN(1'b0)) dut_t (
    .clk(clk), .rst(rst), .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready_t),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready_t), .out_valid(out_valid_t),
    .out_ready(out_ready), .out_s(out_s_t), .out_e(out_e_t), .out_f(out_f_t), .out_id(out_id_t), .busy(busy_t));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
  endtask
  task automatic xfer(input logic sel, input logic [11:0] d, input logic es, input logic [2:0] ee,
                      input logic [3:0] ef, input logic [2:0] ee_t, input logic [3:0] ef_t);
    int n;
    @(negedge clk);
    if (sel) begin b_valid = 1; b_data = d; end else begin a_valid = 1; a_data = d; end
    #1 chk("ready", sel ? b_ready : a_ready, 1);
    @(posedge clk);
    #1 a_valid = 0; b_valid = 0;
    wait_valid(n);
    chk("latency", n, 3);
    chk("s", out_s, es);
    chk("e", out_e, ee);
    chk("f", out_f, ef);
    chk("id", out_id, sel);
    chk("e_trunc", out_e_t, ee_t);
    chk("f_trunc", out_f_t, ef_t);
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    chk("valid_clr", out_valid, 0);
  endtask
  task automatic do_reset();
    rst = 1;
    #2 rst = 0;
  endtask
  initial begin
    int n, seen;
    #3;
    chk("rst_ready", {a_ready, b_ready}, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out", {out_s, out_e, out_f, out_id}, 0);
    @(negedge clk) rst = 0;
    xfer(0, 12'h000, 0, 3'd0, 4'h0, 3'd0, 4'h0);
    xfer(0, 12'h07D, 0, 3'd4, 4'h8, 3'd3, 4'hf);
    xfer(0, 12'hF83, 1, 3'd4, 4'h8, 3'd3, 4'hf);
    xfer(1, 12'h800, 1, 3'd7, 4'hf, 3'd7, 4'hf);
    xfer(1, 12'h7FF, 0, 3'd7, 4'hf, 3'd7, 4'hf);
    xfer(1, 12'h00A, 0, 3'd0, 4'ha, 3'd0, 4'ha);
    xfer(0, 12'h019, 0, 3'd1, 4'hd, 3'd1, 4'hc);
    // both requesters out of reset, consumer stalls
    do_reset();
    @(negedge clk);
    a_valid = 1; b_valid = 1; a_data = 12'h07D; b_data = 12'h00A;
    #1 chk("both_a_ready", a_ready, 1);
    chk("both_b_ready", b_ready, 0);
    @(posedge clk);
    #1 wait_valid(n);
    chk("both_first_id", out_id, 0);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", {out_s, out_e, out_f}, {1'b0, 3'd4, 4'h8});
      chk("hold_ready", {a_ready, b_ready}, 0);
    end
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    chk("rr_b_ready", {a_ready, b_ready}, 2'b01);
    @(posedge clk);
    #1 a_valid = 0; b_valid = 0;
    wait_valid(n);
    chk("second_id", out_id, 1);
    chk("second_f", {out_e, out_f}, {3'd0, 4'ha});
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    // continuous contention alternates the grant
    do_reset();
    a_valid = 1; b_valid = 1; a_data = 12'h07D; b_data = 12'hF83; out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 wait_valid(n);
      chk("rr_id", out_id, k % 2);
      chk("rr_s", out_s, k % 2);
    end
    @(posedge clk);
    #1 a_valid = 0; b_valid = 0; out_ready = 0;
    // reset while the sample is in NORM
    do_reset();
    @(negedge clk) a_valid = 1; a_data = 12'h07D;
    @(posedge clk);
    #1 a_valid = 0;
    @(posedge clk);
    #1 rst = 1;
    #2 rst = 0;
    chk("abort_busy", busy, 0);
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1 seen |= out_valid;
    end
    chk("abort_no_valid", seen, 0);
    @(negedge clk) a_valid = 1; b_valid = 1;
    #1 chk("abort_grant_a", {a_ready, b_ready}, 2'b10);
    a_valid = 0; b_valid = 0;
    xfer(1, 12'h800, 1, 3'd7, 4'hf, 3'd7, 4'hf);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
